sap1_fetch_unit: RTL
====================

# sap1_fetch_unit

Bus initiator and instruction sequencer for the SAP-1 core; the master that drives the 16×8 synchronous program/data memory. Fetches the instruction at PC and decodes the opcode nibble. Resolves JMP/JZ/HLT internally and reads operands for memory-reference ops. Hands {opcode, operand} to the execute unit over a valid/ready handshake.

## Interface
- No parameters. Memory depth 16, word width 8, and opcode encodings are fixed constants in `sap1_pkg`.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `run` in 1: leave IDLE and start fetching.
- `mem_addr` out 4: memory address.
- `mem_read` out 1: read strobe; memory latches `mem[mem_addr]` into `mem_rdata` on the edge where `mem_read`=1.
- `mem_write` out 1: held 0; this block never writes.
- `mem_wdata` out 8: held 0x00.
- `mem_rdata` in 8: memory read data; valid in the cycle after the read edge.
- `ex_valid` out 1: issue valid.
- `ex_opcode` out 4: issued opcode.
- `ex_operand` out 8: operand byte; 0x00 for OUT.
- `ex_ready` in 1: execute unit accepts the issue.
- `zero_flag` in 1: accumulator-zero flag from the execute unit.
- `pc` out 4: program counter.
- `halted` out 1: HLT executed.

## Operation
- Opcodes:
  - 0x0 LDA, 0x1 ADD, 0x2 SUB, 0x3 AND, 0x4 OR, 0x5 XOR: memory-reference ops.
  - 0x6 JMP, 0x7 JZ, 0xE OUT, 0xF HLT.
  - 0x8–0xD: NOP.
- Instruction layout is IR[7:4] opcode, IR[3:0] address.
- FSM states: IDLE, F_REQ, F_WAIT, DECODE, O_REQ, O_WAIT, ISSUE, HALT.
  - IDLE: `run`=1 → F_REQ.
  - F_REQ: `mem_addr`=pc, `mem_read`=1 → F_WAIT.
  - F_WAIT: IR ← `mem_rdata`; pc ← pc+1 (4-bit, wraps 15→0) → DECODE.
  - DECODE, opcodes 0–5: → O_REQ.
  - DECODE, JMP: pc ← IR[3:0] → F_REQ.
  - DECODE, JZ: if `zero_flag`=1, pc ← IR[3:0]; → F_REQ.
  - DECODE, OUT: operand ← 0x00 → ISSUE.
  - DECODE, HLT: → HALT.
  - DECODE, NOP: → F_REQ.
  - O_REQ: `mem_addr`=IR[3:0], `mem_read`=1 → O_WAIT.
  - O_WAIT: operand ← `mem_rdata` → ISSUE.
  - ISSUE: `ex_valid`=1; on `ex_valid`&&`ex_ready` → F_REQ.
  - HALT: `halted`=1, `mem_read`=0; terminal until reset. `run` is ignored.
- `mem_read` is 1 only in F_REQ and O_REQ.
- `mem_addr` is pc in F_REQ and IDLE, IR[3:0] in O_REQ, and otherwise holds its last value.
- `run` is sampled only in IDLE.
- `zero_flag` is sampled only in DECODE. The execute unit must update it no later than 1 cycle after a handshake.

## Timing
- Reset values: `pc`=0, `mem_addr`=0, `mem_read`=0, `mem_write`=0, `mem_wdata`=0x00, `ex_valid`=0, `ex_opcode`=0, `ex_operand`=0x00, `halted`=0. State resets to IDLE.
- Reset mid-operation (any state, including mid-ISSUE): all outputs take their reset values immediately (asynchronous); any pending issue is dropped.
- All outputs are Moore; they are driven from registers or state only, with no combinational path from `ex_ready` or `mem_rdata`.
- Memory read latency is exactly 1 cycle. Data is captured at the end of the *_WAIT cycle.
- Cycles from F_REQ entry to the next F_REQ entry:
  - ALU op: 6, with `ex_ready`=1.
  - OUT: 4.
  - JMP, JZ, NOP: 3.
- ISSUE holds `ex_valid`, `ex_opcode`, and `ex_operand` stable until the handshake. `ex_valid` drops in the cycle after acceptance.
- pc wrap: fetch at 15 → pc=0.
- JMP to the current address loops forever and is legal.

## Structure
- `sap1_pkg`: opcode localparams and the FSM state enum; depth and width constants are shared with the memory block.
- No sub-module. The FSM, IR, operand, and PC registers live in one module.

## Test plan
- Reset, then pulse `run` with mem[0]=0x0A and mem[10]=0x0A → first issue is opcode 0, operand 0x0A, 6 cycles after F_REQ entry; pc=1.
- `ex_ready` held 0 for 5 cycles during ISSUE → `ex_valid` and `ex_operand` stay stable; no `mem_read` is issued; fetch resumes 1 cycle after `ex_ready`=1.
- JZ: mem[7]=0x70 → with `zero_flag`=1, next fetch address is 0x0; with `zero_flag`=0, next fetch address is 0x8.
- JMP: mem[6]=0x68, then mem[8]=0xE0, mem[9]=0xF0 → issues OUT with operand 0x00, then `halted`=1 and `mem_read` stays 0 for 20 cycles.
- Wrap: mem[15]=0x80 (NOP), pc=15 → next fetch address is 0x0.
- Assert `rst_n`=0 mid-ISSUE → `ex_valid`=0 and `pc`=0 before the next edge; state returns to IDLE and waits for `run`.

Source files
------------

// File: rtl/sap1_pkg.sv
// -----------------------------------------------------------------------------
// sap1_pkg
// Shared constants for the SAP-1 core: memory geometry, opcode encodings and
// the fetch-unit FSM state type. The memory block uses the same depth and width
// constants, so the two stay consistent.
// -----------------------------------------------------------------------------
package sap1_pkg;

    localparam int MEM_DEPTH = 16;
    localparam int ADDR_W    = 4;
    localparam int WORD_W    = 8;

    localparam logic [3:0] OP_LDA = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_AND = 4'h3;
    localparam logic [3:0] OP_OR  = 4'h4;
    localparam logic [3:0] OP_XOR = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JZ  = 4'h7;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_F_REQ,
        S_F_WAIT,
        S_DECODE,
        S_O_REQ,
        S_O_WAIT,
        S_ISSUE,
        S_HALT
    } fetch_state_t;

    // LDA..XOR occupy the bottom of the opcode space and all read an operand.
    function automatic logic is_mem_ref(input logic [3:0] op);
        return (op <= OP_XOR);
    endfunction

endpackage

// File: rtl/sap1_fetch_unit.sv
// -----------------------------------------------------------------------------
// sap1_fetch_unit
// Bus initiator and instruction sequencer of the SAP-1 core. Fetches the
// instruction at pc, resolves JMP/JZ/HLT/NOP locally, reads the operand for
// memory-reference ops and hands {opcode, operand} to the execute unit over a
// valid/ready handshake.
//
// Ports
//   clk, rst_n   : clock, asynchronous active-low reset
//   run          : start fetching (only looked at while idle)
//   mem_addr     : memory address
//   mem_read     : read strobe, memory captures on the edge where it is 1
//   mem_write    : tied 0 (read-only initiator)
//   mem_wdata    : tied 0x00
//   mem_rdata    : read data, valid the cycle after the read edge
//   ex_valid     : issue valid
//   ex_opcode    : issued opcode
//   ex_operand   : issued operand byte (0x00 for OUT)
//   ex_ready     : execute unit accepts the issue
//   zero_flag    : accumulator-zero flag, looked at in DECODE only
//   pc           : program counter
//   halted       : HLT has been executed
// -----------------------------------------------------------------------------
module sap1_fetch_unit
    import sap1_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    output logic [3:0] mem_addr,
    output logic       mem_read,
    output logic       mem_write,
    output logic [7:0] mem_wdata,
    input  logic [7:0] mem_rdata,
    output logic       ex_valid,
    output logic [3:0] ex_opcode,
    output logic [7:0] ex_operand,
    input  logic       ex_ready,
    input  logic       zero_flag,
    output logic [3:0] pc,
    output logic       halted
);

    fetch_state_t r_state;
    fetch_state_t w_state_nxt;

    logic [3:0] r_pc;
    logic [7:0] r_ir;
    logic [7:0] r_operand;
    logic [3:0] r_addr_last;

    logic [3:0] w_pc_nxt;
    logic [7:0] w_ir_nxt;
    logic [7:0] w_operand_nxt;
    logic [3:0] w_mem_addr;
    logic [3:0] w_op;

    assign w_op = r_ir[7:4];

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Datapath registers; reset so every output has a defined reset value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc        <= 4'h0;
            r_ir        <= 8'h00;
            r_operand   <= 8'h00;
            r_addr_last <= 4'h0;
        end else begin
            r_pc        <= w_pc_nxt;
            r_ir        <= w_ir_nxt;
            r_operand   <= w_operand_nxt;
            r_addr_last <= w_mem_addr;
        end
    end

    // Next-state and datapath update
    always_comb begin
        w_state_nxt   = r_state;
        w_pc_nxt      = r_pc;
        w_ir_nxt      = r_ir;
        w_operand_nxt = r_operand;

        case (r_state)
            S_IDLE: begin
                if (run) begin
                    w_state_nxt = S_F_REQ;
                end
            end
            S_F_REQ: begin
                w_state_nxt = S_F_WAIT;
            end
            S_F_WAIT: begin
                w_ir_nxt    = mem_rdata;
                w_pc_nxt    = r_pc + 4'd1;   // 4-bit, wraps 15 -> 0
                w_state_nxt = S_DECODE;
            end
            S_DECODE: begin
                if (is_mem_ref(w_op)) begin
                    w_state_nxt = S_O_REQ;
                end else begin
                    case (w_op)
                        OP_JMP: begin
                            w_pc_nxt    = r_ir[3:0];
                            w_state_nxt = S_F_REQ;
                        end
                        OP_JZ: begin
                            if (zero_flag) begin
                                w_pc_nxt = r_ir[3:0];
                            end
                            w_state_nxt = S_F_REQ;
                        end
                        OP_OUT: begin
                            w_operand_nxt = 8'h00;
                            w_state_nxt   = S_ISSUE;
                        end
                        OP_HLT: begin
                            w_state_nxt = S_HALT;
                        end
                        default: begin
                            w_state_nxt = S_F_REQ;   // 0x8-0xD are NOPs
                        end
                    endcase
                end
            end
            S_O_REQ: begin
                w_state_nxt = S_O_WAIT;
            end
            S_O_WAIT: begin
                w_operand_nxt = mem_rdata;
                w_state_nxt   = S_ISSUE;
            end
            S_ISSUE: begin
                if (ex_ready) begin
                    w_state_nxt = S_F_REQ;
                end
            end
            S_HALT: begin
                w_state_nxt = S_HALT;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Address mux: outside the request states the bus keeps its last address,
    // which r_addr_last remembers.
    always_comb begin
        w_mem_addr = r_addr_last;
        case (r_state)
            S_IDLE, S_F_REQ: w_mem_addr = r_pc;
            S_O_REQ:         w_mem_addr = r_ir[3:0];
            default:         w_mem_addr = r_addr_last;
        endcase
    end

    // All outputs come from state or registers only (Moore).
    assign mem_addr   = w_mem_addr;
    assign mem_read   = (r_state == S_F_REQ) || (r_state == S_O_REQ);
    assign mem_write  = 1'b0;
    assign mem_wdata  = 8'h00;
    assign ex_valid   = (r_state == S_ISSUE);
    assign ex_opcode  = r_ir[7:4];
    assign ex_operand = r_operand;
    assign pc         = r_pc;
    assign halted     = (r_state == S_HALT);

endmodule
